// File: rtl/encoder_pkg.sv
// Shared definitions for the RV32I instruction encoder: request op codes,
// base opcodes and funct fields (common with the controller's decode),
// encoder FSM states and immediate range helpers.
package encoder_pkg;

  // Symbolic operations accepted on the request port; other codes are rejected.
  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_ADDI = 4'd4,
    OP_LW   = 4'd5,
    OP_SW   = 4'd6,
    OP_BEQ  = 4'd7,
    OP_LUI  = 4'd8
  } op_e;

  // Base opcodes, bits [6:0] of the instruction word.
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  // funct3 values, bits [14:12].
  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_AND     = 3'b111;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_ADDI    = 3'b000;
  localparam logic [2:0] F3_LW      = 3'b010;
  localparam logic [2:0] F3_SW      = 3'b010;
  localparam logic [2:0] F3_BEQ     = 3'b000;

  // funct7 values, bits [31:25].
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_SUB  = 7'b0100000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // True when imm is representable as a signed 12-bit value (-2048..2047).
  function automatic logic fits_imm12(input logic [31:0] imm);
    return (imm[31:11] == {21{imm[11]}});
  endfunction

  // True when imm is a legal branch offset: signed 13-bit and even (-4096..4094).
  function automatic logic fits_bimm(input logic [31:0] imm);
    return (imm[31:12] == {20{imm[12]}}) && !imm[0];
  endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational packer: symbolic op plus register/immediate fields in,
// 32-bit RV32I word and an illegal flag out. Fields an op does not use
// are simply not placed in the word.
module instr_pack
  import encoder_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] imm,
  output logic [31:0] word,
  output logic        illegal
);

  // Select the instruction format for the op and range-check its immediate.
  always_comb begin
    word    = '0;
    illegal = 1'b0;
    case (op)
      OP_ADD:  word = {F7_BASE, rs2, rs1, F3_ADD_SUB, rd, OPC_OP};
      OP_SUB:  word = {F7_SUB,  rs2, rs1, F3_ADD_SUB, rd, OPC_OP};
      OP_AND:  word = {F7_BASE, rs2, rs1, F3_AND,     rd, OPC_OP};
      OP_OR:   word = {F7_BASE, rs2, rs1, F3_OR,      rd, OPC_OP};
      OP_ADDI: begin
        word    = {imm[11:0], rs1, F3_ADDI, rd, OPC_OP_IMM};
        illegal = !fits_imm12(imm);
      end
      OP_LW: begin
        word    = {imm[11:0], rs1, F3_LW, rd, OPC_LOAD};
        illegal = !fits_imm12(imm);
      end
      OP_SW: begin
        word    = {imm[11:5], rs2, rs1, F3_SW, imm[4:0], OPC_STORE};
        illegal = !fits_imm12(imm);
      end
      OP_BEQ: begin
        // B-type scatters the offset; bit 0 is implicit and must be zero.
        word    = {imm[12], imm[10:5], rs2, rs1, F3_BEQ, imm[4:1], imm[11], OPC_BRANCH};
        illegal = !fits_bimm(imm);
      end
      OP_LUI:  word = {imm[31:12], rd, OPC_LUI};
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Instruction encoder: accepts symbolic requests, packs them into RV32I
// words and streams them into instruction memory at consecutive word
// addresses. One-entry output register gives full throughput while the
// memory keeps wr_ready high.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | after reset, waiting for start
// ST_RUN  | accepting requests; drain flag set once req_last accepted
// ST_DONE | program fully written, waiting for next start
module instr_encoder
  import encoder_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_op,
  input  logic [4:0]        req_rd,
  input  logic [4:0]        req_rs1,
  input  logic [4:0]        req_rs2,
  input  logic [31:0]       req_imm,
  input  logic              req_last,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              done,
  output logic              err,
  output logic [CNT_W-1:0]  err_count
);

  state_e            state_q, state_d;
  logic              drain_q, drain_d;
  logic              wr_valid_q, wr_valid_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [31:0]       wr_data_q, wr_data_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  err_count_q, err_count_d;

  logic [31:0]       pack_word;
  logic              pack_illegal;
  logic              accept;
  logic              wr_fire;

  instr_pack u_pack (
    .op      (req_op),
    .rd      (req_rd),
    .rs1     (req_rs1),
    .rs2     (req_rs2),
    .imm     (req_imm),
    .word    (pack_word),
    .illegal (pack_illegal)
  );

  // A request may enter whenever the output register is empty or emptying this cycle.
  always_comb begin
    req_ready = (state_q == ST_RUN) && !drain_q && (!wr_valid_q || wr_ready);
    accept    = req_valid && req_ready;
    wr_fire   = wr_valid_q && wr_ready;
  end

  // Next-state and datapath update: write completion first, then a new acceptance may reload.
  always_comb begin
    state_d     = state_q;
    drain_d     = drain_q;
    wr_valid_d  = wr_valid_q;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    err_d       = 1'b0;
    err_count_d = err_count_q;

    if (wr_fire) begin
      wr_valid_d = 1'b0;
      wr_addr_d  = wr_addr_q + ADDR_W'(4);
    end

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d     = ST_RUN;
          drain_d     = 1'b0;
          wr_addr_d   = base_addr & ~ADDR_W'(3);
          err_count_d = '0;
        end
      end
      ST_RUN: begin
        if (accept) begin
          if (pack_illegal) begin
            err_d = 1'b1;
            if (err_count_q != {CNT_W{1'b1}}) begin
              err_count_d = err_count_q + CNT_W'(1);
            end
          end else begin
            wr_valid_d = 1'b1;
            wr_data_d  = pack_word;
          end
          if (req_last) begin
            drain_d = 1'b1;
          end
        end
        // Finish on the same edge the last word leaves, so done follows the final handshake.
        if (drain_d && !wr_valid_d) begin
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset discards any in-flight word.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      drain_q     <= 1'b0;
      wr_valid_q  <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      err_q       <= 1'b0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      drain_q     <= drain_d;
      wr_valid_q  <= wr_valid_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      err_q       <= err_d;
      err_count_q <= err_count_d;
    end
  end

  assign wr_valid  = wr_valid_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign err       = err_q;
  assign err_count = err_count_q;
  assign done      = (state_q == ST_DONE);

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: directed programs plus randomized programs with
// random memory back-pressure, checked against a field-arithmetic encoder
// model and an expected-write scoreboard.
module tb_instr_encoder;
  import encoder_pkg::*;

  localparam int ADDR_W = 10;
  localparam int CNT_W  = 8;
  localparam int AMASK  = (1 << ADDR_W) - 1;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [3:0]        req_op = '0;
  logic [4:0]        req_rd = '0;
  logic [4:0]        req_rs1 = '0;
  logic [4:0]        req_rs2 = '0;
  logic [31:0]       req_imm = '0;
  logic              req_last = 1'b0;
  logic              wr_valid;
  logic              wr_ready = 1'b1;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic              done;
  logic              err;
  logic [CNT_W-1:0]  err_count;

  always #5 clk = ~clk;

  instr_encoder #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .base_addr (base_addr),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_rd    (req_rd),
    .req_rs1   (req_rs1),
    .req_rs2   (req_rs2),
    .req_imm   (req_imm),
    .req_last  (req_last),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .done      (done),
    .err       (err),
    .err_count (err_count)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic void ref_encode(input int op, input int rd, input int rs1, input int rs2,
                                     input int imm, output logic [31:0] w, output bit bad);
    logic [31:0] d, s1, s2, u;
    d  = 32'(rd) << 7;
    s1 = 32'(rs1) << 15;
    s2 = 32'(rs2) << 20;
    u  = 32'(imm);
    w  = '0;
    bad = 1'b0;
    case (op)
      int'(OP_ADD):  w = 32'h33 | d | s1 | s2;
      int'(OP_SUB):  w = 32'h33 | d | s1 | s2 | (32'h20 << 25);
      int'(OP_AND):  w = 32'h33 | d | s1 | s2 | (32'd7 << 12);
      int'(OP_OR):   w = 32'h33 | d | s1 | s2 | (32'd6 << 12);
      int'(OP_ADDI): begin
        bad = (imm < -2048) || (imm > 2047);
        w = 32'h13 | d | s1 | ((u & 32'hFFF) << 20);
      end
      int'(OP_LW): begin
        bad = (imm < -2048) || (imm > 2047);
        w = 32'h03 | d | s1 | (32'd2 << 12) | ((u & 32'hFFF) << 20);
      end
      int'(OP_SW): begin
        bad = (imm < -2048) || (imm > 2047);
        w = 32'h23 | s1 | s2 | (32'd2 << 12) | ((u & 32'h1F) << 7) | (((u >> 5) & 32'h7F) << 25);
      end
      int'(OP_BEQ): begin
        bad = (imm < -4096) || (imm > 4094) || (imm % 2 != 0);
        w = 32'h63 | s1 | s2 | (((u >> 12) & 32'h1) << 31) | (((u >> 5) & 32'h3F) << 25)
          | (((u >> 1) & 32'hF) << 8) | (((u >> 11) & 32'h1) << 7);
      end
      int'(OP_LUI):  w = 32'h37 | d | (u & 32'hFFFFF000);
      default:       bad = 1'b1;
    endcase
  endfunction

  logic [31:0] exp_data_q[$];
  int          exp_addr_q[$];
  logic [31:0] wlog[$];
  int          wlog_addr[$];
  int addr_model = 0;
  int err_exp = 0;
  int err_seen = 0;
  int cyc = 0;
  int ready_mode = 0;

  function automatic void model_accept(input int op, input int rd, input int rs1, input int rs2, input int imm);
    logic [31:0] w;
    bit bad;
    ref_encode(op, rd, rs1, rs2, imm, w, bad);
    if (bad) begin
      err_exp++;
    end else begin
      exp_data_q.push_back(w);
      exp_addr_q.push_back(addr_model);
      addr_model = (addr_model + 4) & AMASK;
    end
  endfunction

  always @(posedge clk) cyc++;

  // Memory back-pressure: 0 always ready, 1 random, 2 stalled.
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       wr_ready = 1'b1;
      1:       wr_ready = 1'($urandom_range(0, 1));
      default: wr_ready = 1'b0;
    endcase
  end

  // Write monitor / scoreboard, sampled mid-cycle.
  logic              prev_stall = 1'b0;
  logic [31:0]       prev_data = '0;
  logic [ADDR_W-1:0] prev_addr = '0;
  always @(negedge clk) begin
    if (reset_n) begin
      if (err) err_seen++;
      if (prev_stall) begin
        check("hold_valid", 32'(wr_valid), 1);
        check("hold_addr", 32'(wr_addr), 32'(prev_addr));
        check("hold_data", wr_data, prev_data);
      end
      if (wr_valid && !wr_ready) check("stall_ready", 32'(req_ready), 0);
      if (wr_valid && wr_ready) begin
        check("wr_expected", 32'(exp_data_q.size() != 0), 1);
        if (exp_data_q.size() != 0) begin
          check("wr_addr", 32'(wr_addr), 32'(exp_addr_q.pop_front()));
          check("wr_data", wr_data, exp_data_q.pop_front());
        end
        wlog.push_back(wr_data);
        wlog_addr.push_back(int'(wr_addr));
      end
      prev_stall = wr_valid && !wr_ready;
      prev_data  = wr_data;
      prev_addr  = wr_addr;
    end else begin
      prev_stall = 1'b0;
    end
  end

  // ---------------- stimulus tasks ----------------
  task automatic start_prog(input int base);
    base_addr = ADDR_W'(base);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    addr_model = base & AMASK & ~3;
    err_exp = 0;
    err_seen = 0;
    wlog.delete();
    wlog_addr.delete();
  endtask

  task automatic send(input int op, input int rd, input int rs1, input int rs2, input int imm, input bit last);
    req_op   = 4'(op);
    req_rd   = 5'(rd);
    req_rs1  = 5'(rs1);
    req_rs2  = 5'(rs2);
    req_imm  = 32'(imm);
    req_last = last;
    req_valid = 1'b1;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (req_ready) begin
        model_accept(op, rd, rs1, rs2, imm);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_last  = 1'b0;
        return;
      end
    end
    check("accept_timeout", 32'(req_ready), 1);
    req_valid = 1'b0;
    req_last  = 1'b0;
  endtask

  task automatic end_prog(input string tag);
    int exp_cnt;
    for (int n = 0; n < 500; n++) begin
      @(negedge clk);
      if (done) break;
    end
    check({tag, "_done"}, 32'(done), 1);
    @(posedge clk);
    #1;
    exp_cnt = (err_exp > 255) ? 255 : err_exp;
    check({tag, "_errpulses"}, err_seen, err_exp);
    check({tag, "_errcount"}, 32'(err_count), exp_cnt);
    check({tag, "_pending"}, exp_data_q.size(), 0);
    check({tag, "_endaddr"}, 32'(wr_addr), addr_model);
  endtask

  function automatic int rand_imm();
    int edges[9] = '{-2048, 2047, 2048, -2049, -4096, 4094, 4095, 4096, -4098};
    case ($urandom_range(0, 3))
      0:       return int'($urandom_range(0, 4200)) - 2100;
      1:       return int'($urandom_range(0, 8400)) - 4200;
      2:       return int'($urandom);
      default: return edges[$urandom_range(0, 8)];
    endcase
  endfunction

  function automatic int rand_op();
    int s = int'($urandom_range(0, 9));
    return (s == 9) ? 9 + int'($urandom_range(0, 6)) : s;
  endfunction

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int c0;
    // Reset values
    repeat (3) @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 0);
    check("rst_wr_valid", 32'(wr_valid), 0);
    check("rst_wr_addr", 32'(wr_addr), 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_done", 32'(done), 0);
    check("rst_err", 32'(err), 0);
    check("rst_err_count", 32'(err_count), 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check("idle_ready", 32'(req_ready), 0);

    // Single ADDI, latency and done timing
    ready_mode = 0;
    start_prog(32'h040);
    send(int'(OP_ADDI), 1, 0, 0, 5, 1'b1);
    @(negedge clk);
    check("t1_valid", 32'(wr_valid), 1);
    check("t1_data", wr_data, 32'h00500093);
    check("t1_addr", 32'(wr_addr), 32'h040);
    check("t1_done_early", 32'(done), 0);
    @(negedge clk);
    check("t1_done", 32'(done), 1);
    check("t1_valid_low", 32'(wr_valid), 0);
    end_prog("t1");

    // Back-to-back stream at full rate
    start_prog(32'h100);
    c0 = cyc;
    send(int'(OP_ADD), 3, 1, 2, 0, 1'b0);
    send(int'(OP_SUB), 3, 1, 2, 0, 1'b0);
    send(int'(OP_LW), 5, 2, 0, 8, 1'b0);
    send(int'(OP_SW), 0, 2, 5, 12, 1'b1);
    check("t2_tput", cyc - c0, 4);
    end_prog("t2");
    check("t2_nwr", wlog.size(), 4);
    if (wlog.size() == 4) begin
      check("t2_w0", wlog[0], 32'h002081B3);
      check("t2_w1", wlog[1], 32'h402081B3);
      check("t2_w2", wlog[2], 32'h00812283);
      check("t2_w3", wlog[3], 32'h00512623);
      check("t2_a3", wlog_addr[3], 32'h10C);
    end

    // BEQ and LUI
    start_prog(32'h200);
    send(int'(OP_BEQ), 0, 1, 2, -8, 1'b0);
    send(int'(OP_LUI), 4, 0, 0, 32'h12345000, 1'b1);
    end_prog("t3");
    check("t3_nwr", wlog.size(), 2);
    if (wlog.size() == 2) begin
      check("t3_beq", wlog[0], 32'hFE208CE3);
      check("t3_lui", wlog[1], 32'h12345237);
    end

    // Rejections
    start_prog(32'h080);
    send(int'(OP_ADDI), 1, 1, 0, 2048, 1'b0);
    send(int'(OP_BEQ), 0, 1, 2, 3, 1'b0);
    send(15, 1, 1, 1, 0, 1'b1);
    end_prog("t4");
    check("t4_nwr", wlog.size(), 0);
    check("t4_cnt3", 32'(err_count), 3);
    check("t4_addr", 32'(wr_addr), 32'h080);

    // Back-pressure and address wrap
    start_prog(32'h3FC);
    send(int'(OP_ADDI), 1, 0, 0, 1, 1'b0);
    ready_mode = 2;
    wr_ready = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("t5_stall_valid", 32'(wr_valid), 1);
      check("t5_stall_ready", 32'(req_ready), 0);
    end
    @(posedge clk);
    #1;
    ready_mode = 0;
    wr_ready = 1'b1;
    send(int'(OP_ADDI), 2, 0, 0, 2, 1'b0);
    send(int'(OP_OR), 3, 1, 2, 0, 1'b0);
    send(int'(OP_AND), 4, 1, 2, 0, 1'b1);
    end_prog("t5");
    check("t5_nwr", wlog.size(), 4);
    if (wlog.size() == 4) begin
      check("t5_a0", wlog_addr[0], 32'h3FC);
      check("t5_a1", wlog_addr[1], 32'h000);
      check("t5_a3", wlog_addr[3], 32'h008);
    end

    // Randomized programs under random back-pressure
    ready_mode = 1;
    for (int p = 0; p < 8; p++) begin
      int len = int'($urandom_range(8, 30));
      start_prog(int'($urandom_range(0, AMASK)));
      for (int i = 0; i < len; i++) begin
        send(rand_op(), int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
             int'($urandom_range(0, 31)), rand_imm(), i == len - 1);
      end
      end_prog("rnd");
    end

    // err_count saturation
    ready_mode = 0;
    start_prog(32'h000);
    for (int i = 0; i < 260; i++) send(9 + (i % 7), 0, 0, 0, 0, i == 259);
    end_prog("sat");
    check("sat_cnt", 32'(err_count), 255);

    // Asynchronous reset with a word in flight
    start_prog(32'h020);
    ready_mode = 2;
    wr_ready = 1'b0;
    send(int'(OP_ADDI), 7, 0, 0, 9, 1'b0);
    @(negedge clk);
    check("t8_inflight", 32'(wr_valid), 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("t8_req_ready", 32'(req_ready), 0);
    check("t8_wr_valid", 32'(wr_valid), 0);
    check("t8_wr_addr", 32'(wr_addr), 0);
    check("t8_wr_data", wr_data, 0);
    check("t8_done", 32'(done), 0);
    check("t8_err_count", 32'(err_count), 0);
    exp_data_q.delete();
    exp_addr_q.delete();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    ready_mode = 0;
    wr_ready = 1'b1;
    @(posedge clk);
    #1;
    start_prog(32'h020);
    send(int'(OP_ADDI), 7, 0, 0, 9, 1'b1);
    end_prog("t8");
    check("t8_nwr", wlog.size(), 1);
    if (wlog.size() == 1) check("t8_restart_addr", wlog_addr[0], 32'h020);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
